// File: rtl/mux3_rr_arbiter.sv
// Round-robin owner of the mux_3to1 select: one requester at a time, grant one cycle after request.
// A beat is out_valid && out_ready; a stall freezes grant, sel and the burst count.
module mux3_rr_arbiter #(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] last,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic [2:0] grant,
    output logic       out_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] count;

    logic [1:0] owner;
    logic [1:0] arb_ptr;
    logic [1:0] winner;
    logic       req_any;
    logic       owner_req;
    logic       owner_last;
    logic       beat;
    logic       cap_hit;
    logic       rel;

    function automatic logic [1:0] inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] idx);
        logic [2:0] oh;
        case (idx)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            default: oh = 3'b100;
        endcase
        return oh;
    endfunction

    // Priority order p, p+1, p+2 (mod 3); only meaningful when req != 0.
    function automatic logic [1:0] pick(input logic [2:0] r, input logic [1:0] p);
        logic [1:0] c0;
        logic [1:0] c1;
        logic [1:0] c2;
        c0 = p;
        c1 = inc3(c0);
        c2 = inc3(c1);
        if (r[c0])
            return c0;
        else if (r[c1])
            return c1;
        else
            return c2;
    endfunction

    // sel always tracks grant, so it doubles as the owner index.
    assign owner      = sel;
    assign req_any    = |req;
    assign owner_req  = req[owner];
    assign owner_last = last[owner];
    assign out_valid  = |(grant & req);
    assign busy       = (state == GRANT);
    assign beat       = out_valid & out_ready;
    assign cap_hit    = (count == CNT_W'(MAX_BEATS - 1));
    assign rel        = (state == GRANT) && (!owner_req || (beat && (owner_last || cap_hit)));

    // On release the pointer has already moved past the owner for this cycle's pick.
    assign arb_ptr = (state == GRANT) ? inc3(owner) : rr_ptr;
    assign winner  = pick(req, arb_ptr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= 3'b000;
            sel    <= 2'b00;
            count  <= '0;
            rr_ptr <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_any) begin
                        state <= GRANT;
                        grant <= onehot(winner);
                        sel   <= winner;
                        count <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        rr_ptr <= inc3(owner);
                        count  <= '0;
                        if (req_any) begin
                            grant <= onehot(winner);
                            sel   <= winner;
                        end else begin
                            state <= IDLE;
                            grant <= 3'b000;
                        end
                    end else if (beat) begin
                        count <= count + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// Scoreboarded bench for mux3_rr_arbiter: expected beat owners are queued as stimulus is set up
// and compared by a negedge monitor each time a handshake completes.
module tb_mux3_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] last;
    logic       out_ready;
    logic [1:0] sel;
    logic [2:0] grant;
    logic       out_valid;
    logic       busy;

    typedef struct {
        logic [2:0] g;
        logic [1:0] s;
    } beat_t;

    beat_t exp_q[$];
    int    checks;
    int    failures;
    int    beat_cnt;
    int    base_beats;
    bit    sb_en;

    mux3_rr_arbiter #(.MAX_BEATS(4), .CNT_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .last      (last),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .out_valid (out_valid),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_beat(input logic [2:0] g, input int n);
        beat_t b;
        b.g = g;
        b.s = (g == 3'b001) ? 2'b00 : (g == 3'b010) ? 2'b01 : 2'b10;
        for (int i = 0; i < n; i++) exp_q.push_back(b);
    endtask

    task automatic scoreboard_mon();
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst_n && sb_en && out_valid && out_ready) begin
                beat_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got grant=%b sel=%b, expected no beat", grant, sel);
                end else begin
                    e = exp_q.pop_front();
                    if (grant !== e.g || sel !== e.s) begin
                        failures++;
                        $display("FAIL beat_owner: got grant=%b sel=%b, expected grant=%b sel=%b",
                                 grant, sel, e.g, e.s);
                    end
                end
            end
        end
    endtask

    task automatic do_reset();
        sb_en     = 1'b0;
        rst_n     = 1'b0;
        req       = 3'b000;
        last      = 3'b000;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n      = 1'b1;
        sb_en      = 1'b1;
        base_beats = beat_cnt;
    endtask

    task automatic go_idle();
        req  = 3'b000;
        last = 3'b000;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        sb_en     = 1'b0;
        rst_n     = 1'b0;
        req       = 3'b111;
        last      = 3'b000;
        out_ready = 1'b1;
        #1;
        checks++;
        if (grant !== 3'b000 || sel !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got grant=%b sel=%b vld=%b busy=%b, expected 000 00 0 0",
                     grant, sel, out_valid, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last  = 3'b111;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (grant !== 3'b100) begin
            failures++;
            $display("FAIL reset_preburst: got grant=%b, expected 100", grant);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 3'b000 || sel !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_async: got grant=%b sel=%b vld=%b busy=%b, expected 000 00 0 0",
                     grant, sel, out_valid, busy);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        last  = 3'b000;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 3'b001 || sel !== 2'b00 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_grant: got grant=%b sel=%b vld=%b, expected 001 00 1",
                     grant, sel, out_valid);
        end
        go_idle();
    endtask

    task automatic test_single();
        do_reset();
        out_ready = 1'b1;
        req       = 3'b010;
        push_beat(3'b010, 2);
        @(negedge clk);
        checks++;
        if (grant !== 3'b000) begin
            failures++;
            $display("FAIL single_early: got grant=%b, expected 000 before the clock", grant);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 3'b010 || sel !== 2'b01 || out_valid !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_grant: got grant=%b sel=%b vld=%b busy=%b, expected 010 01 1 1",
                     grant, sel, out_valid, busy);
        end
        @(posedge clk);
        #1;
        last = 3'b010;
        @(posedge clk);
        #1;
        req  = 3'b000;
        last = 3'b000;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_no_third: got out_valid=%b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: got grant=%b busy=%b, expected 000 0", grant, busy);
        end
        checks++;
        if (beat_cnt - base_beats !== 2 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL single_beats: got %0d beats (%0d pending), expected 2 (0)",
                     beat_cnt - base_beats, exp_q.size());
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        out_ready = 1'b1;
        req       = 3'b001;
        push_beat(3'b001, 8);
        @(posedge clk);
        #1;
        repeat (8) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (beat_cnt - base_beats !== 8 || grant !== 3'b001 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL cap_regrant: got %0d beats grant=%b vld=%b, expected 8 001 1",
                     beat_cnt - base_beats, grant, out_valid);
        end
        req = 3'b011;
        push_beat(3'b001, 4);
        push_beat(3'b010, 4);
        push_beat(3'b001, 4);
        repeat (12) begin
            @(posedge clk);
            #1;
        end
        go_idle();
        checks++;
        if (beat_cnt - base_beats !== 20 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL cap_beats: got %0d beats (%0d pending), expected 20 (0)",
                     beat_cnt - base_beats, exp_q.size());
        end
    endtask

    task automatic test_rotation();
        do_reset();
        out_ready = 1'b1;
        last      = 3'b111;
        req       = 3'b111;
        for (int i = 0; i < 2; i++) begin
            push_beat(3'b001, 1);
            push_beat(3'b010, 1);
            push_beat(3'b100, 1);
        end
        @(posedge clk);
        #1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        go_idle();
        checks++;
        if (beat_cnt - base_beats !== 6 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL rotation_beats: got %0d beats (%0d pending), expected 6 (0)",
                     beat_cnt - base_beats, exp_q.size());
        end
        checks++;
        if (grant !== 3'b000 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rotation_idle: got grant=%b busy=%b, expected 000 0", grant, busy);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        req       = 3'b100;
        @(posedge clk);
        #1;
        req = 3'b101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b100 || sel !== 2'b10 || out_valid !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got grant=%b sel=%b vld=%b busy=%b, expected 100 10 1 1",
                         i, grant, sel, out_valid, busy);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (beat_cnt - base_beats !== 0) begin
            failures++;
            $display("FAIL stall_beats: got %0d beats, expected 0", beat_cnt - base_beats);
        end
        out_ready = 1'b1;
        push_beat(3'b100, 4);
        push_beat(3'b001, 1);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        go_idle();
        checks++;
        if (beat_cnt - base_beats !== 5 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL stall_resume: got %0d beats (%0d pending), expected 5 (0)",
                     beat_cnt - base_beats, exp_q.size());
        end
    endtask

    task automatic test_abort();
        do_reset();
        out_ready = 1'b1;
        req       = 3'b011;
        push_beat(3'b001, 1);
        push_beat(3'b010, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        req = 3'b110;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || grant !== 3'b001) begin
            failures++;
            $display("FAIL abort_cycle: got grant=%b vld=%b, expected 001 0", grant, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 3'b010 || sel !== 2'b01 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL abort_regrant: got grant=%b sel=%b vld=%b, expected 010 01 1",
                     grant, sel, out_valid);
        end
        last = 3'b010;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== 3'b100 || sel !== 2'b10) begin
            failures++;
            $display("FAIL abort_next: got grant=%b sel=%b, expected 100 10", grant, sel);
        end
        go_idle();
        checks++;
        if (beat_cnt - base_beats !== 2 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_beats: got %0d beats (%0d pending), expected 2 (0)",
                     beat_cnt - base_beats, exp_q.size());
        end
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        beat_cnt   = 0;
        base_beats = 0;
        sb_en      = 1'b0;
        rst_n      = 1'b0;
        req        = 3'b000;
        last       = 3'b000;
        out_ready  = 1'b0;
        fork
            scoreboard_mon();
        join_none
        test_reset();
        test_single();
        test_burst_cap();
        test_rotation();
        test_backpressure();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
